ours_vld_rdy_rr_disp: RTL and testbench
=======================================

OURS_VLD_RDY_RR_DISP -- requirements
Module: ours_vld_rdy_rr_disp

Interface
REQ-001 The block SHALL have parameter N_OUTPUT, default 2, giving the number of downstream channels (legal range 1..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the payload width.
REQ-003 The block SHALL have parameter BACKEND_DOMAIN, default 0, which is passed through only and has no functional effect.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
- clk  input  1  clock; all state changes on the rising edge
- rstn  input  1  reset; asynchronous assert, active-low
REQ-005 The block SHALL have these data ports.
- in_vld  input  1  upstream beat valid
- in_rdy  output  1  upstream beat accepted when in_vld & in_rdy
- in_data  input  DATA_WIDTH  upstream payload
- out_vld  output  N_OUTPUT  one-hot downstream valid, one bit per channel
- out_rdy  input  N_OUTPUT  per-channel downstream ready
- out_data  output  DATA_WIDTH  payload shared by all channels; meaningful only where out_vld is set

Function
REQ-006 The block SHALL be a one-deep registered dispatcher with two states, EMPTY and FULL, holding a data register, a one-hot target register tgt and a last-target index last_id.
REQ-007 The block SHALL assert out_vld only in FULL, with out_vld = tgt, and out_data = data register.
REQ-008 The block SHALL drive in_rdy = (state==EMPTY) | (|(out_vld & out_rdy)), which is a combinational path from out_rdy to in_rdy.
REQ-009 A downstream handshake SHALL occur only on channel i with out_vld[i] & out_rdy[i]; out_rdy on non-target channels SHALL be ignored for the handshake.
REQ-010 The block SHALL capture a beat on in_vld & in_rdy: data register <= in_data, tgt <= onehot(sel), last_id <= sel.
REQ-011 Target selection sel SHALL search channels in the order last_id+1, last_id+2, ... (mod N_OUTPUT) and pick the first channel whose out_rdy is 1 in the capture cycle.
REQ-012 If no out_rdy is set in the capture cycle, sel SHALL be (last_id+1) mod N_OUTPUT.
REQ-013 The wrap-around from N_OUTPUT-1 to 0 SHALL be exact for non-power-of-two N_OUTPUT; the index width SHALL be max(1, $clog2(N_OUTPUT)).
REQ-014 State transitions SHALL be as follows.
- EMPTY & in_vld -> FULL
- EMPTY & !in_vld -> EMPTY
- FULL & downstream handshake & in_vld -> FULL, with a new beat captured in the same cycle
- FULL & handshake & !in_vld -> EMPTY
- FULL & no handshake -> FULL, with tgt, data and last_id unchanged
REQ-015 Once set, out_vld and out_data SHALL remain stable until that channel's handshake, even if out_rdy on other channels rises.
REQ-016 Latency SHALL be one cycle from upstream accept to out_vld asserted; sustained throughput SHALL be one beat per cycle when the targeted channels are ready.
REQ-017 When N_OUTPUT==1, sel SHALL always be 0 and the block SHALL behave as a one-deep pipeline register.
REQ-018 The block SHALL NOT lose or duplicate beats: every accepted upstream beat is presented exactly once and completes on exactly one channel.

Reset
REQ-019 While rstn=0 the block SHALL be in state EMPTY, with out_vld=0, in_rdy=0, data register=0, tgt=0 and last_id=N_OUTPUT-1.
REQ-020 Reset assertion mid-transfer SHALL discard any held beat immediately, without waiting for a clock edge.
REQ-021 After deassertion, in_rdy SHALL be 1 in the first cycle, and the first beat SHALL target channel 0 if out_rdy[0]=1 or if no out_rdy is set.
REQ-022 Reset deassertion SHALL be synchronized externally; the block SHALL not add its own synchronizer.

Verification
REQ-023 The bench SHALL use N_OUTPUT=4 and DATA_WIDTH=8 for all scenarios below.
REQ-024 Scenario, all ready: after reset, out_rdy=4'b1111, stream 0x10..0x17 -> out_vld sequence 0001,0010,0100,1000,0001,... one beat per cycle; in_rdy stays 1.
REQ-025 Scenario, skip: out_rdy=4'b1001, last_id=0, beat 0xA5 -> out_vld=4'b1000 next cycle; following beat -> 4'b0001.
REQ-026 Scenario, backpressure: capture 0x3C to channel 1 with out_rdy=0 for 5 cycles -> out_vld=4'b0010, out_data=0x3C and in_rdy=0 are held stable; out_rdy[2] toggling has no effect; out_rdy[1]=1 -> handshake, then EMPTY.
REQ-027 Scenario, simultaneous: FULL with a handshake and in_vld=1 in the same cycle -> new beat captured with no bubble and state stays FULL.
REQ-028 Scenario, reset mid-operation: assert rstn=0 between clock edges while FULL -> out_vld=0 immediately; after release, the first beat goes to channel 0.
REQ-029 Scenario, non-power-of-two: N_OUTPUT=3, all ready, 7 beats -> channel order 0,1,2,0,1,2,0.

Source files
------------

// File: rtl/ours_vld_rdy_rr_disp_if.sv
// Valid/ready bundle for the round-robin dispatcher: one upstream channel in,
// N_OUTPUT one-hot downstream channels out sharing a single data bus.
interface ours_vld_rdy_rr_disp_if #(
    parameter int N_OUTPUT   = 2,
    parameter int DATA_WIDTH = 32
);
    logic                  in_vld;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] in_data;
    logic [N_OUTPUT-1:0]   out_vld;
    logic [N_OUTPUT-1:0]   out_rdy;
    logic [DATA_WIDTH-1:0] out_data;

    // Driver side: upstream producer plus downstream consumers
    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_data
    );

    // Dispatcher side
    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_data
    );
endinterface

// File: rtl/ours_vld_rdy_rr_disp.sv
// One-deep registered dispatcher: each accepted beat is steered to the next
// ready downstream channel in round-robin order after the last one used.
module ours_vld_rdy_rr_disp #(
    parameter int N_OUTPUT       = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int BACKEND_DOMAIN = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    ours_vld_rdy_rr_disp_if.slave   bus
);
    // BACKEND_DOMAIN is a pass-through tag only; the zero product keeps it referenced
    localparam int IDX_W = ((N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1) + 0 * BACKEND_DOMAIN;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUTPUT - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [N_OUTPUT-1:0]   tgt_reg;
    logic [IDX_W-1:0]      last_id_reg;

    logic [IDX_W-1:0]      sel;
    logic [IDX_W-1:0]      cand;
    logic                  found;
    logic [N_OUTPUT-1:0]   sel_onehot;
    logic                  hs;
    logic                  accept;

    assign bus.out_vld  = (state_reg == FULL) ? tgt_reg : '0;
    assign bus.out_data = data_reg;
    assign hs           = |(bus.out_vld & bus.out_rdy);
    // Gated by rstn so in_rdy is low throughout reset even though state is EMPTY
    assign bus.in_rdy   = rstn & ((state_reg == EMPTY) | hs);
    assign accept       = bus.in_vld & bus.in_rdy;

    // Search last_id+1, last_id+2, ... with exact modulo wrap; default is last_id+1
    always_comb begin
        sel   = (last_id_reg == LAST_IDX) ? '0 : last_id_reg + 1'b1;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_OUTPUT; k++) begin
            cand = IDX_W'((int'(last_id_reg) + k) % N_OUTPUT);
            if (!found && bus.out_rdy[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N_OUTPUT; gi++) begin : g_onehot
        assign sel_onehot[gi] = (sel == IDX_W'(gi));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= EMPTY;
            data_reg    <= '0;
            tgt_reg     <= '0;
            last_id_reg <= LAST_IDX;
        end else if (accept) begin
            // Covers both EMPTY capture and back-to-back capture on a handshake
            state_reg   <= FULL;
            data_reg    <= bus.in_data;
            tgt_reg     <= sel_onehot;
            last_id_reg <= sel;
        end else if (hs) begin
            state_reg   <= EMPTY;
        end
    end
endmodule

// File: tb/tb_ours_vld_rdy_rr_disp.sv
// Bench for the round-robin dispatcher: directed scenarios with literal
// expectations plus a randomized phase checked against a queue-based model.
module tb_ours_vld_rdy_rr_disp;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ours_vld_rdy_rr_disp_if #(.N_OUTPUT(4), .DATA_WIDTH(8)) bus4 ();
    ours_vld_rdy_rr_disp_if #(.N_OUTPUT(3), .DATA_WIDTH(8)) bus3 ();

    ours_vld_rdy_rr_disp #(.N_OUTPUT(4), .DATA_WIDTH(8), .BACKEND_DOMAIN(0)) dut4 (
        .clk(clk), .rstn(rstn), .bus(bus4.slave));
    ours_vld_rdy_rr_disp #(.N_OUTPUT(3), .DATA_WIDTH(8), .BACKEND_DOMAIN(1)) dut3 (
        .clk(clk), .rstn(rstn), .bus(bus3.slave));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the N=4 instance: at most one held beat, its target
    // channel index and the last channel used; plus an in-order scoreboard.
    bit         m_full = 1'b0;
    int         m_tgt = 0;
    int         m_last = 3;
    logic [7:0] m_data = '0;
    logic [7:0] sb[$];

    always @(negedge clk) begin
        logic [3:0] exp_vld;
        bit         exp_rdy, hs, acc, found;
        int         sel, idx;
        logic [7:0] front;
        if (!rstn) begin
            m_full = 1'b0; m_last = 3; m_data = '0; sb.delete();
            chk("rst_out_vld", bus4.out_vld, 0);
            chk("rst_in_rdy", bus4.in_rdy, 0);
        end else begin
            exp_vld = m_full ? 4'(1 << m_tgt) : 4'b0000;
            exp_rdy = !m_full || bus4.out_rdy[m_tgt];
            chk("model_out_vld", bus4.out_vld, exp_vld);
            chk("model_in_rdy", bus4.in_rdy, exp_rdy);
            if (m_full) chk("model_out_data", bus4.out_data, m_data);
            hs  = m_full && bus4.out_rdy[m_tgt];
            acc = bus4.in_vld && exp_rdy;
            if (hs) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    front = sb.pop_front();
                    chk("sb_data", bus4.out_data, front);
                    $display("txn ch=%0d data=%02h", m_tgt, bus4.out_data);
                end
            end
            if (acc) begin
                sel = (m_last + 1) % 4;
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    idx = (m_last + k) % 4;
                    if (!found && bus4.out_rdy[idx]) begin sel = idx; found = 1'b1; end
                end
                sb.push_back(bus4.in_data);
                m_full = 1'b1; m_tgt = sel; m_last = sel; m_data = bus4.in_data;
            end else if (hs) begin
                m_full = 1'b0;
            end
        end
    end

    initial begin
        logic [3:0] exp4 [8];
        logic [2:0] exp3 [7];
        exp4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

        bus4.in_vld = 0; bus4.in_data = '0; bus4.out_rdy = '0;
        bus3.in_vld = 0; bus3.in_data = '0; bus3.out_rdy = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_rdy_low", bus4.in_rdy, 0);
        rstn = 1'b1;
        #1;
        chk("post_reset_in_rdy", bus4.in_rdy, 1);

        // All ready: 4 channels stream 0x10..0x17; 3 channels stream 7 beats
        bus4.out_rdy = 4'b1111;
        bus3.out_rdy = 3'b111;
        for (int i = 0; i < 8; i++) begin
            bus4.in_vld = 1; bus4.in_data = 8'(8'h10 + i);
            bus3.in_vld = (i < 7); bus3.in_data = 8'(8'h20 + i);
            step();
            chk("allrdy_vld", bus4.out_vld, exp4[i]);
            chk("allrdy_data", bus4.out_data, 8'(8'h10 + i));
            chk("allrdy_in_rdy", bus4.in_rdy, 1);
            if (i < 7) chk("n3_order", bus3.out_vld, exp3[i]);
        end
        bus4.in_vld = 0; bus3.in_vld = 0;
        step();
        chk("allrdy_drained", bus4.out_vld, 0);
        chk("n3_drained", bus3.out_vld, 0);

        // Park last_id on channel 0
        bus4.in_vld = 1; bus4.in_data = 8'h55;
        step();
        chk("park_ch0", bus4.out_vld, 4'b0001);
        bus4.in_vld = 0;
        step();

        // Skip: only channels 0 and 3 ready
        bus4.out_rdy = 4'b1001; bus4.in_vld = 1; bus4.in_data = 8'hA5;
        step();
        chk("skip_to_ch3", bus4.out_vld, 4'b1000);
        chk("skip_data", bus4.out_data, 8'hA5);
        bus4.in_data = 8'h5A;
        step();
        chk("skip_wrap_ch0", bus4.out_vld, 4'b0001);
        chk("skip_wrap_data", bus4.out_data, 8'h5A);
        bus4.in_vld = 0;
        step();

        // Backpressure: nothing ready at capture -> default last_id+1 = channel 1
        bus4.out_rdy = 4'b0000; bus4.in_vld = 1; bus4.in_data = 8'h3C;
        step();
        bus4.in_vld = 0;
        for (int k = 0; k < 5; k++) begin
            bus4.out_rdy = (k % 2 == 1) ? 4'b0100 : 4'b0000;
            #1;
            chk("bp_vld_hold", bus4.out_vld, 4'b0010);
            chk("bp_data_hold", bus4.out_data, 8'h3C);
            chk("bp_in_rdy_low", bus4.in_rdy, 0);
            step();
        end
        bus4.out_rdy = 4'b0010;
        #1;
        chk("bp_release_in_rdy", bus4.in_rdy, 1);
        step();
        chk("bp_empty", bus4.out_vld, 0);

        // Simultaneous handshake and capture, no bubble
        bus4.out_rdy = 4'b1111; bus4.in_vld = 1; bus4.in_data = 8'h77;
        step();
        chk("simul_first", bus4.out_vld, 4'b0100);
        bus4.in_data = 8'h88;
        #1;
        chk("simul_in_rdy", bus4.in_rdy, 1);
        step();
        chk("simul_second", bus4.out_vld, 4'b1000);
        chk("simul_data", bus4.out_data, 8'h88);
        bus4.in_vld = 0;
        step();

        // Reset mid-operation while FULL
        bus4.out_rdy = 4'b0000; bus4.in_vld = 1; bus4.in_data = 8'h99;
        step();
        bus4.in_vld = 0;
        chk("pre_rst_full", bus4.out_vld, 4'b0001);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_vld", bus4.out_vld, 0);
        chk("async_rst_data", bus4.out_data, 0);
        @(posedge clk); @(posedge clk);
        #1;
        rstn = 1'b1;
        bus4.in_vld = 1; bus4.in_data = 8'h42;
        #1;
        chk("rerst_in_rdy", bus4.in_rdy, 1);
        step();
        chk("rerst_first_ch0", bus4.out_vld, 4'b0001);
        chk("rerst_data", bus4.out_data, 8'h42);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            bus4.in_vld  = ($urandom_range(0, 3) != 0);
            bus4.in_data = 8'($urandom);
            bus4.out_rdy = 4'($urandom);
            step();
        end
        bus4.in_vld = 0; bus4.out_rdy = 4'b1111;
        repeat (3) step();
        chk("sb_empty_end", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
